// File: rtl/result_drain.sv
// rtl/result_drain.sv - snapshots an MxM result matrix and streams it row-major; optional RESULT_DRAIN_RELU_EN clamp
module result_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int M          = 3,
    parameter int IDX_W      = (M > 1) ? $clog2(M) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] result_in [0:M-1][0:M-1],
    input  logic                  done_in,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [IDX_W-1:0]      m_row,
    output logic [IDX_W-1:0]      m_col,
    output logic                  m_last,
    output logic                  busy,
    output logic                  drain_done,
    output logic                  overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(M - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_done_q;
    logic [DATA_WIDTH-1:0] r_buf [0:M-1][0:M-1];
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic [IDX_W-1:0]      r_m_row;
    logic [IDX_W-1:0]      r_m_col;
    logic                  r_m_last;
    logic                  r_busy;
    logic                  r_drain_done;
    logic                  r_overrun;

    logic                  w_rise;
    logic                  w_xfer;
    logic                  w_col_wrap;
    logic [IDX_W-1:0]      w_next_row;
    logic [IDX_W-1:0]      w_next_col;
    logic                  w_next_last;

    // Optional ReLU applied as words enter the snapshot buffer, so it costs no latency.
    function automatic logic [DATA_WIDTH-1:0] f_clamp(input logic [DATA_WIDTH-1:0] i_word);
`ifdef RESULT_DRAIN_RELU_EN
        return i_word[DATA_WIDTH-1] ? '0 : i_word;
`else
        return i_word;
`endif
    endfunction

    assign w_rise = done_in & ~r_done_q;
    assign w_xfer = r_m_valid & m_ready;

    // Next row-major position; only consulted when the current beat is not the last one.
    always_comb begin
        w_col_wrap  = (r_m_col == LAST_IDX);
        w_next_col  = w_col_wrap ? '0 : r_m_col + 1'b1;
        w_next_row  = w_col_wrap ? r_m_row + 1'b1 : r_m_row;
        w_next_last = (w_next_row == LAST_IDX) && (w_next_col == LAST_IDX);
    end

    // Capture/drain FSM; every stream output is a register so m_valid never depends on m_ready.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_done_q     <= 1'b1;
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_m_row      <= '0;
            r_m_col      <= '0;
            r_m_last     <= 1'b0;
            r_busy       <= 1'b0;
            r_drain_done <= 1'b0;
            r_overrun    <= 1'b0;
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < M; j++) begin
                    r_buf[i][j] <= '0;
                end
            end
        end else begin
            r_done_q     <= done_in;
            r_drain_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        for (int i = 0; i < M; i++) begin
                            for (int j = 0; j < M; j++) begin
                                r_buf[i][j] <= f_clamp(result_in[i][j]);
                            end
                        end
                        r_m_data  <= f_clamp(result_in[0][0]);
                        r_m_row   <= '0;
                        r_m_col   <= '0;
                        r_m_last  <= (M == 1);
                        r_m_valid <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The array may finish again before we are done: drop it, but remember.
                    if (w_rise) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_xfer) begin
                        if (r_m_last) begin
                            r_m_valid    <= 1'b0;
                            r_m_data     <= '0;
                            r_m_row      <= '0;
                            r_m_col      <= '0;
                            r_m_last     <= 1'b0;
                            r_busy       <= 1'b0;
                            r_drain_done <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_m_row  <= w_next_row;
                            r_m_col  <= w_next_col;
                            r_m_data <= r_buf[w_next_row][w_next_col];
                            r_m_last <= w_next_last;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;
    assign m_row      = r_m_row;
    assign m_col      = r_m_col;
    assign m_last     = r_m_last;
    assign busy       = r_busy;
    assign drain_done = r_drain_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_result_drain.sv
// tb/tb_result_drain.sv - self-checking bench for result_drain with a queue-based reference model
module tb_result_drain;

    localparam int DW = 32;
    localparam int M  = 3;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    row;
        logic [1:0]    col;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] result_in [0:M-1][0:M-1];
    logic          done_in;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [1:0]    m_row;
    logic [1:0]    m_col;
    logic          m_last;
    logic          busy;
    logic          drain_done;
    logic          overrun;

    int    errors = 0;
    int    checks = 0;
    beat_t exp_q[$];
    logic  ovr_exp = 1'b0;

    always #5 clk = ~clk;

    result_drain #(.DATA_WIDTH(DW), .M(M)) dut (
        .clk        (clk),
        .reset      (reset),
        .result_in  (result_in),
        .done_in    (done_in),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_row      (m_row),
        .m_col      (m_col),
        .m_last     (m_last),
        .busy       (busy),
        .drain_done (drain_done),
        .overrun    (overrun)
    );

    function automatic logic [DW-1:0] model_clamp(input logic [DW-1:0] w);
`ifdef RESULT_DRAIN_RELU_EN
        return ($signed(w) < 0) ? '0 : w;
`else
        return w;
`endif
    endfunction

    // Expected stream for a snapshot of the current result_in: row-major, last on (M-1,M-1).
    task automatic push_model();
        beat_t b;
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < M; c++) begin
                b.data = model_clamp(result_in[r][c]);
                b.row  = 2'(r);
                b.col  = 2'(c);
                b.last = (r == M - 1) && (c == M - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic load_matrix(input int kind, input int base);
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < M; c++) begin
                result_in[r][c] = (kind != 0) ? $urandom : DW'(base + r * M + c);
            end
        end
    endtask

    task automatic do_reset(input logic done_level);
        @(negedge clk);
        reset   = 1'b0;
        done_in = done_level;
        m_ready = 1'b0;
        @(negedge clk);
        reset   = 1'b1;
        ovr_exp = 1'b0;
        exp_q.delete();
    endtask

    task automatic capture();
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL capture_idle_valid act=%b exp=0", m_valid);
        end
        done_in = 1'b1;
        push_model();
    endtask

    // mode: 0 ready high, 1 ready pattern 1,0,0, 2 random ready.
    task automatic drain(input int mode, input int stop_after, input int inject_at,
                         input bit b2b, input bit scramble);
        int popped   = 0;
        int guard    = 0;
        bit injected = 0;
        while (popped < stop_after && guard < 200) begin
            @(negedge clk);
            guard++;
            done_in = 1'b0;
            checks++;
            if (m_valid !== 1'b1) begin
                errors++;
                $display("FAIL drain_valid beat=%0d act=%b exp=1", popped, m_valid);
            end else begin
                checks++;
                if (m_data !== exp_q[0].data || m_row !== exp_q[0].row ||
                    m_col !== exp_q[0].col || m_last !== exp_q[0].last) begin
                    errors++;
                    $display("FAIL drain_beat beat=%0d act=(%h,%0d,%0d,%b) exp=(%h,%0d,%0d,%b)",
                             popped, m_data, m_row, m_col, m_last,
                             exp_q[0].data, exp_q[0].row, exp_q[0].col, exp_q[0].last);
                end
            end
            checks++;
            if (busy !== 1'b1 || drain_done !== 1'b0) begin
                errors++;
                $display("FAIL drain_busy beat=%0d act=(%b,%b) exp=(1,0)", popped, busy, drain_done);
            end
            if (scramble) load_matrix(1, 0);
            if (inject_at == popped && !injected) begin
                injected = 1;
                done_in  = 1'b1;
                ovr_exp  = 1'b1;
                load_matrix(0, 100);
            end
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((guard - 1) % 3 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (m_ready && m_valid === 1'b1) begin
                void'(exp_q.pop_front());
                popped++;
            end
        end
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("FAIL drain_timeout popped=%0d exp=%0d", popped, stop_after);
        end
        if (stop_after == M * M) begin
            @(negedge clk);
            done_in = 1'b0;
            m_ready = 1'b0;
            checks++;
            if (m_valid !== 1'b0 || busy !== 1'b0 || drain_done !== 1'b1) begin
                errors++;
                $display("FAIL drain_end act=(v%b,b%b,d%b) exp=(v0,b0,d1)", m_valid, busy, drain_done);
            end
            if (b2b) begin
                load_matrix(1, 0);
                done_in = 1'b1;
                push_model();
            end
            @(negedge clk);
            done_in = 1'b0;
            checks++;
            if (drain_done !== 1'b0 || m_valid !== b2b) begin
                errors++;
                $display("FAIL drain_after act=(d%b,v%b) exp=(d0,v%b)", drain_done, m_valid, b2b);
            end
            checks++;
            if (overrun !== ovr_exp) begin
                errors++;
                $display("FAIL overrun_state act=%b exp=%b", overrun, ovr_exp);
            end
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        checks++;
        if ({m_valid, m_data, m_row, m_col, m_last, busy, drain_done, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs act=(%b,%h,%0d,%0d,%b,%b,%b,%b) exp=all zero",
                     m_valid, m_data, m_row, m_col, m_last, busy, drain_done, overrun);
        end
    endtask

    task automatic test_basic();
        load_matrix(0, 1);
        capture();
        drain(0, M * M, -1, 0, 0);
    endtask

    task automatic test_stall();
        load_matrix(0, 1);
        capture();
        drain(1, M * M, -1, 0, 0);
    endtask

    task automatic test_overrun();
        load_matrix(0, 1);
        capture();
        drain(0, M * M, 3, 0, 0);
        load_matrix(1, 0);
        capture();
        drain(0, M * M, M * M - 1, 0, 0);
    endtask

    task automatic test_back_to_back();
        load_matrix(1, 0);
        capture();
        drain(2, M * M, -1, 1, 0);
        drain(0, M * M, -1, 0, 0);
    endtask

    task automatic test_reset_mid();
        load_matrix(0, 1);
        capture();
        drain(0, 4, -1, 0, 0);
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_row !== 2'd1 || m_col !== 2'd1) begin
            errors++;
            $display("FAIL mid_pending act=(v%b,%0d,%0d) exp=(v1,1,1)", m_valid, m_row, m_col);
        end
        reset   = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        reset   = 1'b1;
        ovr_exp = 1'b0;
        exp_q.delete();
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || drain_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset act=(v%b,b%b,o%b,d%b) exp=(0,0,0,0)", m_valid, busy, overrun, drain_done);
        end
        @(negedge clk);
        checks++;
        if (drain_done !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_done act=(d%b,v%b) exp=(0,0)", drain_done, m_valid);
        end
        load_matrix(0, 50);
        capture();
        drain(0, M * M, -1, 0, 0);
    endtask

    task automatic test_done_high();
        do_reset(1'b1);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL done_high_capture act=(v%b,b%b) exp=(0,0)", m_valid, busy);
            end
        end
        done_in = 1'b0;
        load_matrix(0, 20);
        capture();
        drain(0, M * M, -1, 0, 0);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b0) begin
                errors++;
                $display("FAIL done_single_drain act=%b exp=0", m_valid);
            end
        end
    endtask

    task automatic test_relu();
        load_matrix(1, 0);
        result_in[0][0] = 32'hFFFF_FFFB;
        result_in[0][1] = 32'd0;
        result_in[0][2] = 32'd7;
        capture();
        drain(2, M * M, -1, 0, 1);
    endtask

    task automatic test_random();
        bit pending = 0;
        bit nb;
        int inj;
        for (int it = 0; it < 8; it++) begin
            if (!pending) begin
                load_matrix(1, 0);
                capture();
            end
            inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, M * M - 1)) : -1;
            nb  = (it < 7) && (inj != M * M - 1) && ($urandom_range(0, 1) == 1);
            drain(2, M * M, inj, nb, 1);
            pending = nb;
        end
    endtask

    initial begin
        reset   = 1'b0;
        done_in = 1'b0;
        m_ready = 1'b0;
        load_matrix(0, 0);
        test_reset();
        test_basic();
        test_stall();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_done_high();
        test_relu();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_drain.md
Name: result_drain

Overview:
- Downstream stage of the MxM systolic array.
- Snapshots the full result matrix on the rising edge of the array's done level.
- Serialises the matrix row-major, one element per beat, over a valid/ready master stream to the host or writeback path.
- Frees the array for the next computation as soon as the snapshot is taken.

Parameters:
DATA_WIDTH, 32, width of each result element
M, 3, array dimension; matrix is MxM, M >= 1
IDX_W, $clog2(M) (min 1), width of the row/col index outputs

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low reset; reset==0 at a clk edge resets the block
result_in  input  DATA_WIDTH x [0:M-1][0:M-1]  result matrix from the array
done_in  input  1  done level from the array; a 0->1 transition triggers capture
m_valid  output  1  output beat valid
m_ready  input  1  downstream accepts beat
m_data  output  DATA_WIDTH  element value
m_row  output  IDX_W  row index of the current beat
m_col  output  IDX_W  column index of the current beat
m_last  output  1  high on the beat for (M-1,M-1)
busy  output  1  high while in DRAIN
drain_done  output  1  one-cycle pulse after the final beat is accepted
overrun  output  1  sticky; set when a done_in rising edge arrives while busy

Behaviour:
- Reset (reset==0 at clk edge):
  - state=IDLE.
  - m_valid=0, m_data=0, m_row=0, m_col=0, m_last=0, busy=0, drain_done=0, overrun=0.
  - Snapshot buffer cleared to 0.
  - done_q=1, so a done_in already high coming out of reset does not trigger a capture.
- done_q register: samples done_in every cycle. Rise = done_in & ~done_q.
- States:
  - IDLE:
    - On rise, copy all M*M result_in words into the buffer at that edge.
    - Go to DRAIN; next cycle m_valid=1, m_row=0, m_col=0, busy=1.
    - Capture-to-first-valid latency: 1 cycle.
  - DRAIN:
    - m_data = buffer[m_row][m_col], driven from registers.
    - A beat transfers when m_valid & m_ready.
    - On transfer: m_col increments; at m_col==M-1, m_col wraps to 0 and m_row increments.
    - m_last = (m_row==M-1 && m_col==M-1).
    - On transfer of the last beat: go to IDLE, m_valid=0, busy=0, drain_done=1 for exactly the next cycle.
    - Throughput: 1 beat/cycle when m_ready is held high. M*M beats total. Final transfer occurs M*M cycles after the first valid.
- Handshake rules:
  - While m_valid & ~m_ready, m_data/m_row/m_col/m_last hold stable.
  - m_valid never drops before its beat transfers (except on reset).
  - m_valid does not depend combinationally on m_ready.
- Boundary conditions:
  - Rise while in DRAIN, including the final-transfer cycle: ignored, buffer untouched, overrun set. overrun clears only on reset.
  - Rise in the cycle after returning to IDLE: accepted normally; back-to-back drains are allowed.
  - result_in changes after capture: no effect on the drain in progress.
  - Reset mid-drain: stream aborts immediately; m_valid=0 next cycle; no m_last or drain_done.
  - M=1: single beat with m_last=1, row=col=0.
- No arithmetic on the data path other than the optional clamp.

Optional Feature:
- Macro: RESULT_DRAIN_RELU_EN.
- Defined: each word is treated as signed two's complement at capture. Negative values are stored as 0; non-negative values pass unchanged. The clamp adds no latency.
- Undefined: words are stored and emitted bit-exact.

Test Plan:
- Reset, result_in=1..9 (row-major), done_in 0->1, m_ready=1 -> first valid 1 cycle after rise; data 1..9 on 9 consecutive cycles; rows/cols (0,0)..(2,2); m_last only on 9; drain_done one cycle after; busy falls.
- Same load, m_ready toggling 1,0,0,1,... -> each beat held stable while stalled; 9 beats in order; no duplicates or drops.
- Rise during the 4th beat with new matrix 100..108 -> output still 1..9; overrun=1 and stays 1 until reset.
- Reset asserted (reset=0) while beat 5 is pending -> next cycle m_valid=0, busy=0, overrun=0; no drain_done; a subsequent rise drains from (0,0).
- done_in held high through reset release -> no capture. Then done_in 1->0->1 -> one drain.
- With RESULT_DRAIN_RELU_EN, result_in row0 = {-5, 0, 7} -> beats 0, 0, 7. Without the macro -> 0xFFFFFFFB, 0, 7.
